// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad by driving one column low at a time and
//   reading the rows back. A decoded key is accepted only after it has been
//   stable for DEBOUNCE_SCANS full frames. The last two accepted keys are
//   kept as an 8-bit value.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad columns, one-cold (active column driven 0)
//   value_clr  synchronous clear of value
//   key_code   hex code of the last accepted key
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high while the accepted key is considered pressed
//   value      {previous key, latest key}
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       value_clr,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] value
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       acc_cnt;      // keys seen so far in this frame: 0, 1, 2 = many
  logic [3:0]       acc_code;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;

  logic       slot_end, frame_end;
  logic [1:0] col_cnt, col_row;
  logic [3:0] col_code;
  logic [2:0] sum_cnt;
  logic [1:0] tot_cnt;
  logic [3:0] tot_code;
  logic       accept, release_done;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign col       = ~(4'b0001 << col_idx);
  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);

  // Rows pressed in the active column, as read through the synchronizer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    col_cnt = 2'd0;
    col_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_row = 2'(r);
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
      end
    end
    col_code = key_map(col_row, col_idx);
    sum_cnt  = {1'b0, acc_cnt} + {1'b0, col_cnt};
    tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    tot_code = (col_cnt != 2'd0) ? col_code : acc_code;
  end

  // Debounce FSM; tot_* is the complete frame result when frame_end is high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    accept       = 1'b0;
    release_done = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: if (tot_cnt == 2'd1) begin
          cand_d = tot_code;
          if (DEB_N == 4'd1) begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
            accept  = 1'b1;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (tot_cnt == 2'd1 && tot_code == cand_q) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: if (tot_cnt == 2'd0) begin
          if (DEB_N == 4'd1) begin
            state_d      = IDLE;
            cnt_d        = 4'd0;
            release_done = 1'b1;
          end else begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end
        end
        default: begin // RELEASE
          if (tot_cnt == 2'd0) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              state_d      = IDLE;
              cnt_d        = 4'd0;
              release_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_idx   <= 2'd0;
      row_s1    <= 4'b1111;
      row_s2    <= 4'b1111;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'h0;
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      value     <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      row_s1    <= row;
      row_s2    <= row_s1;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_valid <= accept;

      if (slot_end) begin
        div_q   <= '0;
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'h0;
        end else begin
          acc_cnt  <= tot_cnt;
          acc_code <= tot_code;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      if (accept) begin
        key_code <= tot_code;
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end

      // A clear coincident with an accept keeps only the new key.
      if (value_clr) value <= accept ? {4'h0, tot_code} : 8'h00;
      else if (accept) value <= {value[3:0], tot_code};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle
//   frames). A keypad model pulls row[r] low when col[c] is low and key
//   (r,c) is pressed. A frame-level reference model derives the expected
//   outputs from the set of keys held during each whole frame.
module tb_keypad_scanner;

  localparam int DIV = 4;
  localparam int DS  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       value_clr = 1'b0;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [7:0] value;

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .value_clr(value_clr),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .value(value)
  );

  always #5 clk = ~clk;

  // Pressed keys, bit index row*4+col.
  logic [15:0] keys = 16'h0000;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  function automatic logic [15:0] km(input int r, input int c);
    km = 16'h0001 << (r*4 + c);
  endfunction

  // Reference model state
  int         ph;          // cycle within frame, 0..15
  logic       m_held;
  int         m_streak;
  int         m_rel;
  logic [3:0] m_cand;
  logic [3:0] m_code;
  logic [7:0] m_value;
  logic       m_valid;

  int n_vec = 0;
  int n_bad = 0;
  int pulses;
  int held_falls;
  logic prev_held;

  task automatic model_reset();
    ph = 0; m_held = 0; m_streak = 0; m_rel = 0; m_cand = 0;
    m_code = 0; m_value = 8'h00; m_valid = 0; prev_held = 0;
  endtask

  // Frame result from the whole frame's key set.
  task automatic model_frame(input logic [15:0] m, output logic acc, output logic [3:0] k);
    int n;
    n = $countones(m);
    k = 4'h0;
    acc = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = keymap[i];
    if (!m_held) begin
      if (n == 1 && m_streak > 0 && k == m_cand) m_streak++;
      else if (n == 1 && m_streak == 0) begin m_streak = 1; m_cand = k; end
      else m_streak = 0;
      if (m_streak == DS) begin
        acc = 1; m_held = 1; m_streak = 0; m_rel = 0;
        m_code = k; m_value = {m_value[3:0], k};
      end
    end else begin
      if (n == 0) m_rel++; else m_rel = 0;
      if (m_rel == DS) begin m_held = 0; m_rel = 0; end
    end
  endtask

  // One clock: model update at the edge, compare at the following negedge.
  task automatic tick(input logic clr);
    logic acc;
    logic [3:0] k;
    logic [3:0] exp_col;
    value_clr = clr;
    @(posedge clk);
    acc = 0; k = 0;
    if (ph == 15) model_frame(keys, acc, k);
    m_valid = acc;
    if (clr) m_value = acc ? {4'h0, k} : 8'h00;
    ph = (ph + 1) % 16;
    @(negedge clk);
    value_clr = 1'b0;
    exp_col = ~(4'b0001 << (ph / DIV));
    n_vec += 5;
    if (col !== exp_col) begin n_bad++; $display("FAIL col ph=%0d: got %b expected %b", ph, col, exp_col); end
    if (key_valid !== m_valid) begin n_bad++; $display("FAIL key_valid ph=%0d: got %b expected %b", ph, key_valid, m_valid); end
    if (key_held !== m_held) begin n_bad++; $display("FAIL key_held ph=%0d: got %b expected %b", ph, key_held, m_held); end
    if (key_code !== m_code) begin n_bad++; $display("FAIL key_code ph=%0d: got %h expected %h", ph, key_code, m_code); end
    if (value !== m_value) begin n_bad++; $display("FAIL value ph=%0d: got %h expected %h", ph, value, m_value); end
    if (key_valid === 1'b1) pulses++;
    if (prev_held === 1'b1 && key_held === 1'b0) held_falls++;
    prev_held = key_held;
  endtask

  task automatic run_frame(input logic [15:0] m, input int clr_ph);
    keys = m;
    for (int i = 0; i < 16; i++) tick(i == clr_ph);
  endtask

  task automatic check_reset_values(input string tag);
    n_vec += 5;
    if (col !== 4'b1110) begin n_bad++; $display("FAIL %s col: got %b expected 1110", tag, col); end
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL %s key_valid: got %b expected 0", tag, key_valid); end
    if (key_held !== 1'b0) begin n_bad++; $display("FAIL %s key_held: got %b expected 0", tag, key_held); end
    if (key_code !== 4'h0) begin n_bad++; $display("FAIL %s key_code: got %h expected 0", tag, key_code); end
    if (value !== 8'h00) begin n_bad++; $display("FAIL %s value: got %h expected 00", tag, value); end
  endtask

  // Asynchronous reset between edges, released on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1 check_reset_values("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(16'h0, -1);
    // Partial frame with '5' held, then reset mid-scan with the key still down.
    keys = km(1, 1);
    for (int i = 0; i < 6; i++) tick(1'b0);
    do_reset("reset_mid_scan");
    pulses = 0;
    run_frame(km(1, 1), -1);
    n_vec++;
    if (pulses !== 0) begin n_bad++; $display("FAIL reset_redebounce_early: got %0d pulses expected 0", pulses); end
    run_frame(km(1, 1), -1);
    n_vec++;
    if (pulses !== 1) begin n_bad++; $display("FAIL reset_redebounce: got %0d pulses expected 1", pulses); end
    run_frame(16'h0, -1);
    run_frame(16'h0, -1);
  endtask

  task automatic test_hold5();
    do_reset("reset_hold5");
    pulses = 0; held_falls = 0;
    for (int f = 0; f < 4; f++) run_frame(km(1, 1), -1);
    n_vec += 3;
    if (pulses !== 1) begin n_bad++; $display("FAIL hold5_pulses: got %0d expected 1", pulses); end
    if (value !== 8'h05) begin n_bad++; $display("FAIL hold5_value: got %h expected 05", value); end
    if (key_held !== 1'b1) begin n_bad++; $display("FAIL hold5_held: got %b expected 1", key_held); end
    run_frame(16'h0, -1);
    n_vec++;
    if (key_held !== 1'b1) begin n_bad++; $display("FAIL hold5_held_after1: got %b expected 1", key_held); end
    run_frame(16'h0, -1);
    n_vec++;
    if (held_falls !== 1) begin n_bad++; $display("FAIL hold5_release: got %0d falls expected 1", held_falls); end
    run_frame(16'h0, -1);
  endtask

  task automatic press_release(input logic [15:0] m);
    run_frame(m, -1); run_frame(m, -1);
    run_frame(16'h0, -1); run_frame(16'h0, -1);
  endtask

  task automatic test_sequence();
    pulses = 0;
    press_release(km(0, 3));   // A
    press_release(km(3, 1));   // F
    n_vec += 3;
    if (pulses !== 2) begin n_bad++; $display("FAIL seq_pulses: got %0d expected 2", pulses); end
    if (value !== 8'hAF) begin n_bad++; $display("FAIL seq_value: got %h expected AF", value); end
    if (key_code !== 4'hF) begin n_bad++; $display("FAIL seq_code: got %h expected F", key_code); end
    press_release(km(0, 2));   // 3
    n_vec++;
    if (value !== 8'hF3) begin n_bad++; $display("FAIL seq_value3: got %h expected F3", value); end
  endtask

  task automatic test_bounce();
    logic [7:0] v0;
    v0 = m_value;
    pulses = 0;
    for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? km(2, 2) : 16'h0, -1);
    n_vec += 3;
    if (pulses !== 0) begin n_bad++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
    if (key_held !== 1'b0) begin n_bad++; $display("FAIL bounce_held: got %b expected 0", key_held); end
    if (value !== v0) begin n_bad++; $display("FAIL bounce_value: got %h expected %h", value, v0); end
    run_frame(16'h0, -1);
  endtask

  task automatic test_multi();
    pulses = 0;
    for (int f = 0; f < 3; f++) run_frame(km(0, 0) | km(0, 1), -1);
    n_vec++;
    if (pulses !== 0) begin n_bad++; $display("FAIL multi_12: got %0d pulses expected 0", pulses); end
    run_frame(16'h0, -1); run_frame(16'h0, -1);
    run_frame(km(0, 2), -1); run_frame(km(0, 2), -1);
    held_falls = 0;
    for (int f = 0; f < 3; f++) run_frame(km(0, 2) | km(1, 2), -1);
    n_vec += 2;
    if (pulses !== 1) begin n_bad++; $display("FAIL multi_rollover: got %0d pulses expected 1", pulses); end
    if (key_code !== 4'h3) begin n_bad++; $display("FAIL multi_code: got %h expected 3", key_code); end
    run_frame(16'h0, -1); run_frame(16'h0, -1); run_frame(16'h0, -1);
    n_vec++;
    if (held_falls !== 1) begin n_bad++; $display("FAIL multi_release: got %0d falls expected 1", held_falls); end
  endtask

  task automatic test_value_clr();
    press_release(km(0, 3));
    press_release(km(3, 1));
    pulses = 0;
    run_frame(km(2, 3), -1);
    run_frame(km(2, 3), 15);   // clear on the accepting edge
    n_vec += 2;
    if (value !== 8'h0C) begin n_bad++; $display("FAIL clr_accept_value: got %h expected 0C", value); end
    if (pulses !== 1) begin n_bad++; $display("FAIL clr_accept_pulse: got %0d expected 1", pulses); end
    run_frame(16'h0, -1); run_frame(16'h0, -1);
    run_frame(16'h0, 5);
    n_vec += 2;
    if (value !== 8'h00) begin n_bad++; $display("FAIL clr_alone_value: got %h expected 00", value); end
    if (key_code !== 4'hC) begin n_bad++; $display("FAIL clr_alone_code: got %h expected C", key_code); end
  endtask

  task automatic test_random();
    logic [15:0] m;
    m = 16'h0;
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 5))
        0, 1: ;                                          // keep previous keys
        2:    m = 16'h0;
        3, 4: m = 16'h0001 << $urandom_range(0, 15);
        default: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      run_frame(m, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_hold5();
    test_sequence();
    test_bounce();
    test_multi();
    test_value_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD style) and delivers debounced hex key codes to the front-panel FSM.
- Provides a hex-entry source for the count-down start value as an alternative to the switches.
- Is the input-side counterpart of the multiplexed 7-seg driver: it drives one column low at a time and reads back the rows.
- Assembles the last two keys entered into an 8-bit value.

Parameters:
- SCAN_DIV, 100000: clk cycles per column slot (1 ms at 100 MHz); legal range is 4 or more.
- DEBOUNCE_SCANS, 4: number of consecutive full scan frames a condition must persist before press or release is accepted; legal range is 1 to 15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  4  keypad rows, active-low with external pull-ups, asynchronous to clk
- col  out  4  keypad columns, one-cold; the active column is driven 0
- value_clr  in  1  synchronous clear of value
- key_code  out  4  hex code of the last accepted key
- key_valid  out  1  one-cycle pulse when a new key is accepted
- key_held  out  1  high while the accepted key is considered pressed
- value  out  8  {previous key, latest key}

Behaviour:
- Reset (async assert) sets:
  - col=4'b1110, divider=0, synchronizer flops=4'b1111
  - state=IDLE, debounce count=0
  - key_code=0, key_valid=0, key_held=0, value=8'h00
- Scan:
  - row passes through a 2-FF synchronizer.
  - col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
  - The synchronized row is sampled on the last cycle of each column slot.
  - A frame is columns 0..3 in order. The frame result is evaluated on the last cycle of column 3 and is one of: NONE, SINGLE(code), MULTI.
- Key map (row index 0 = top, col index 0 = left):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM, updated only at frame end:
  - IDLE:
    - SINGLE(k) -> DEBOUNCE, candidate=k, cnt=1.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED and perform the accept actions instead.
  - DEBOUNCE:
    - SINGLE(same k) -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> PRESSED (accept).
    - NONE, MULTI, or a different key -> IDLE, cnt=0.
  - Accept actions (same cycle):
    - key_valid=1 for exactly that cycle
    - key_code=k
    - value={value[3:0],k}
    - key_held=1
  - PRESSED:
    - SINGLE or MULTI -> stay; no new pulse (rollover and ghosting are ignored).
    - NONE -> RELEASE, cnt=1.
  - RELEASE:
    - NONE -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0.
    - Any key seen -> PRESSED, cnt=0.
- Latency:
  - key_valid fires at the end of the DEBOUNCE_SCANS-th consecutive complete frame containing the key.
  - A partial frame counts only if the key was present at its column's sample point.
- value_clr:
  - Sets value=8'h00 on the next edge.
  - If coincident with an accept, value={4'h0,k}; key_valid still pulses.
  - Does not affect key_code, key_held or the FSM.
- Widths: the debounce counter is 4 bits; the divider is wide enough for SCAN_DIV-1 and wraps to 0.
- Reset mid-operation: everything returns to reset values immediately. A key held across reset deassertion must pass full debounce again before it is accepted.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, so a frame is 16 cycles. A keypad model drives row[r]=0 when col[c]==0 and key (r,c) is pressed.)
- Reset: assert rst_n=0 mid-scan.
  -> col=1110, key_valid=0, key_held=0, key_code=0, value=00 immediately.
  -> After release, col steps every 4 cycles.
- Hold '5' (row1,col1) for 4 frames from IDLE.
  -> Exactly one key_valid pulse, at the end of the 2nd full frame, with key_code=5.
  -> value=8'h05 and key_held=1.
  -> After release, key_held drops at the end of the 2nd empty frame.
- Press/release 'A', then press/release 'F'.
  -> Two pulses; value=8'hAF, key_code=F.
  -> Then press '3': value=8'hF3.
- Bounce: toggle '9' present/absent on alternate frames for 8 frames.
  -> No key_valid; key_held stays 0; value unchanged.
- Multi-key cases:
  - From IDLE, press '1'+'2' together -> no pulse.
  - Hold '3' until accepted, then add '6' -> no second pulse.
  - Release both -> key_held falls once.
- value_clr:
  - With value=8'hAF, pulse value_clr on the same cycle 'C' is accepted -> value=8'h0C and key_valid pulses.
  - Later, value_clr alone -> value=8'h00 and key_code stays C.
